// File: rtl/instr_loader.sv
// Serial program loader: parses a framed byte stream (16-bit word count,
// big-endian data words, XOR checksum) and writes the words sequentially
// into instruction RAM starting at BASE_ADDR.
module instr_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned BASE_ADDR  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned MAX_WORDS = (32'd1 << ADDR_WIDTH) - BASE_ADDR;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_CHKLEN, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic [7:0]            xor_q, xor_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic len_too_big;
  logic last_word;

  assign len_too_big = 32'(len_q) > MAX_WORDS;
  assign last_word   = (cnt_q == len_q - CNT_W'(1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_HI;
      S_LEN_HI: if (byte_valid) state_d = S_LEN_LO;
      S_LEN_LO: if (byte_valid) state_d = S_CHKLEN;
      S_CHKLEN: begin
        if (len_too_big)         state_d = S_ERROR;
        else if (len_q == '0)    state_d = S_CHECK;
        else                     state_d = S_DATA;
      end
      S_DATA: if (byte_valid && idx_q == 2'd3 && last_word) state_d = S_CHECK;
      S_CHECK: if (byte_valid) state_d = (byte_data == xor_q) ? S_DONE : S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    len_d     = len_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    xor_d     = xor_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                (state_d == S_CHKLEN) || (state_d == S_DATA) || (state_d == S_CHECK);
    done_d    = (state_d == S_DONE);
    error_d   = (state_d == S_ERROR);
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          xor_d = '0;
          cnt_d = '0;
          idx_d = '0;
        end
      end
      S_LEN_HI: begin
        if (byte_valid) begin
          len_d = {byte_data, 8'h00};
          xor_d = xor_q ^ byte_data;
        end
      end
      S_LEN_LO: begin
        if (byte_valid) begin
          len_d = {len_q[CNT_W-1:8], byte_data};
          xor_d = xor_q ^ byte_data;
        end
      end
      S_CHKLEN: idx_d = '0;
      S_DATA: begin
        if (byte_valid) begin
          word_d = {word_q[DATA_WIDTH-9:0], byte_data};
          xor_d  = xor_q ^ byte_data;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(cnt_q);
            wr_data_d = {word_q[DATA_WIDTH-9:0], byte_data};
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      xor_q     <= '0;
      word_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      xor_q     <= xor_d;
      word_q    <= word_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: a frame-level model derives the expected write list
// and final status from each byte frame; a negedge monitor checks every write
// and the hold behaviour of wr_addr/wr_data.
module tb_instr_loader;

  localparam int unsigned AW   = 9;
  localparam int unsigned DW   = 32;
  localparam int unsigned BASE = 1;
  localparam int          MAXW = (1 << AW) - BASE;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          error;

  instr_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  logic [7:0]  fr[$];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic        m_done;
  logic        m_err;
  logic [7:0]  m_xor;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Every write must match the next model entry; between writes address/data hold
  always @(negedge clk) begin : cmp
    wr_t e;
    if (!reset) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wr_en", 64'(wr_en), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(e.addr));
          chk("wr_data", 64'(wr_data), 64'(e.data));
          m_addr = e.addr;
          m_data = e.data;
        end
      end else begin
        chk("hold_addr", 64'(wr_addr), 64'(m_addr));
        chk("hold_data", 64'(wr_data), 64'(m_data));
      end
    end
  end

  // Frame-level model: expected writes and outcome from the frame bytes
  task automatic build_model();
    int n;
    logic [DW-1:0] w;
    n = int'({fr[0], fr[1]});
    m_xor = fr[0] ^ fr[1];
    if (n > MAXW) begin
      m_done = 1'b0;
      m_err  = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = {fr[2+4*i], fr[3+4*i], fr[4+4*i], fr[5+4*i]};
      m_xor = m_xor ^ fr[2+4*i] ^ fr[3+4*i] ^ fr[4+4*i] ^ fr[5+4*i];
      exp_q.push_back({AW'(BASE + i), w});
    end
    m_done = (fr[2+4*n] == m_xor);
    m_err  = !m_done;
  endtask

  task automatic do_reset();
    exp_q.delete();
    m_addr = '0;
    m_data = '0;
    byte_valid = 1'b0;
    start = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_wr_en",   64'(wr_en),   64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_busy",    64'(busy),    64'(0));
    chk("rst_done",    64'(done),    64'(0));
    chk("rst_error",   64'(error),   64'(0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start",  64'(busy),  64'(1));
    chk("done_after_start",  64'(done),  64'(0));
    chk("error_after_start", 64'(error), 64'(0));
  endtask

  // Drive fr back-to-back, with one idle cycle after LEN_LO
  task automatic send_frame(input int start_at, input int abort_at);
    int n;
    bit ovf;
    bit due;
    n   = int'({fr[0], fr[1]});
    ovf = (n > MAXW);
    due = 1'b0;
    for (int k = 0; k < fr.size(); k++) begin
      @(negedge clk);
      if (due) begin
        chk("wr_en_timing", 64'(wr_en), 64'(1));
        due = 1'b0;
      end
      byte_valid = 1'b1;
      byte_data  = fr[k];
      start      = (k == start_at);
      if (!ovf && k >= 2 && k < 2 + 4*n && ((k - 2) % 4 == 3)) due = 1'b1;
      if (k == abort_at) begin
        @(negedge clk);
        do_reset();
        return;
      end
      if (k == 1) begin
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b0;
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start = 1'b0;
    if (due) chk("wr_en_timing", 64'(wr_en), 64'(1));
  endtask

  task automatic check_end(input string tag);
    chk({tag, "_done"},  64'(done),  64'(m_done));
    chk({tag, "_error"}, 64'(error), 64'(m_err));
    chk({tag, "_busy"},  64'(busy),  64'(0));
    chk({tag, "_pending_writes"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic load_two_word(input logic [7:0] ck);
    fr = '{8'h00, 8'h02, 8'h07, 8'hE0, 8'h00, 8'h00, 8'h44, 8'h00, 8'h00, 8'h00, ck};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    m_addr = '0; m_data = '0; m_done = 1'b0; m_err = 1'b0; m_xor = '0;
    @(negedge clk);
    do_reset();

    // Two-word load, with literal pins on the model
    load_two_word(8'hA1);
    build_model();
    chk("model_w0",  64'(exp_q[0]), 64'({9'd1, 32'h07E00000}));
    chk("model_w1",  64'(exp_q[1]), 64'({9'd2, 32'h44000000}));
    chk("model_xor", 64'(m_xor),    64'(8'hA1));
    pulse_start();
    send_frame(-1, -1);
    check_end("two_word");
    chk("two_word_last_addr", 64'(wr_addr), 64'(2));
    chk("two_word_last_data", 64'(wr_data), 64'(32'h44000000));
    chk("two_word_done_lit",  64'(done),    64'(1));

    // Zero length
    fr = '{8'h00, 8'h00, 8'h00};
    build_model();
    chk("model_zero_done", 64'(m_done), 64'(1));
    pulse_start();
    send_frame(-1, -1);
    check_end("zero_len");

    // Bad checksum: writes still happen, error reported
    load_two_word(8'hA0);
    build_model();
    pulse_start();
    send_frame(-1, -1);
    check_end("bad_chk");
    chk("bad_chk_error_lit", 64'(error), 64'(1));

    // Overflow: N=512 with BASE_ADDR=1, trailing bytes ignored
    fr = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h55};
    build_model();
    pulse_start();
    send_frame(-1, -1);
    check_end("overflow");
    chk("overflow_error_lit", 64'(error), 64'(1));

    // Reset after the 2nd data byte of word 0, then a full reload
    load_two_word(8'hA1);
    build_model();
    pulse_start();
    send_frame(-1, 3);
    chk("abort_pending", 64'(exp_q.size()), 64'(0));
    load_two_word(8'hA1);
    build_model();
    pulse_start();
    send_frame(-1, -1);
    check_end("after_reset");

    // Start during DATA is ignored
    load_two_word(8'hA1);
    build_model();
    pulse_start();
    send_frame(4, -1);
    check_end("start_busy");

    // Bytes while DONE produce no writes and leave done set
    fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_frame(-1, -1);
    check_end("idle_bytes");

    // Largest legal frame: last word lands at the top address
    fr.delete();
    fr.push_back(8'h01);
    fr.push_back(8'hFF);
    for (int i = 0; i < 4*MAXW; i++) fr.push_back(8'($urandom_range(0, 255)));
    fr.push_back(8'h00);
    build_model();
    fr[fr.size()-1] = m_xor;
    m_done = 1'b1;
    m_err  = 1'b0;
    pulse_start();
    send_frame(-1, -1);
    check_end("max_len");
    chk("max_len_top_addr", 64'(wr_addr), 64'(511));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Serial program loader for the instruction memory: receives a framed byte stream (e.g. from the UART receiver), assembles big-endian 32-bit instruction words, and writes them sequentially into a writable instruction RAM starting at `BASE_ADDR`. It is the write side of the instruction-fetch path. The CPU is held by `busy` while a load is in progress. After the load, `done` or `error` reports whether the frame was valid.

## Interface
- `DATA_WIDTH`, 32, instruction word width; fixed at 32, 4 bytes per word.
- `ADDR_WIDTH`, 9, instruction memory address width.
- `BASE_ADDR`, 1, address that receives the first word; address 0 stays untouched.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a new frame.
- `byte_valid`  in  1  `byte_data` is valid this cycle; one byte is accepted per high cycle.
- `byte_data`  in  8  stream byte.
- `wr_en`  out  1  single-cycle memory write strobe.
- `wr_addr`  out  ADDR_WIDTH  write address.
- `wr_data`  out  DATA_WIDTH  write word.
- `busy`  out  1  frame in progress; CPU held in reset/stall.
- `done`  out  1  frame completed with a good checksum; sticky.
- `error`  out  1  frame rejected; sticky.

## Operation
- Frame format, in order:
  - LEN_HI, LEN_LO: 16-bit word count N, MSB first.
  - N×4 data bytes: each word MSB first.
  - CHK: one byte.
- Checksum: running XOR of every byte from LEN_HI through the last data byte. The frame is good iff CHK equals this XOR.
- States: IDLE, LEN_HI, LEN_LO, CHKLEN, DATA, CHECK, DONE, ERROR.
  - IDLE/DONE/ERROR:
    - `start` clears `done` and `error`, clears the XOR and the word counter, and moves to LEN_HI.
    - `byte_valid` is ignored in these states.
  - LEN_HI → LEN_LO → CHKLEN: each transition happens on an accepted byte.
  - CHKLEN (one cycle, consumes no byte):
    - If N > 2**ADDR_WIDTH − BASE_ADDR: go to ERROR, no writes.
    - Else if N == 0: go to CHECK.
    - Else: go to DATA with byte index 0.
  - DATA:
    - Each accepted byte shifts into the word register (`word <= {word[23:0], byte}`).
    - The 4th byte of a word triggers a write; the index wraps to 0.
    - After word N−1 is written, go to CHECK.
  - CHECK: on an accepted byte, go to DONE if it equals the XOR, else ERROR.
- Write addressing: word i (0-based) goes to `BASE_ADDR + i`. `wr_data` is the assembled word, with the first received byte in bits [31:24].
- Writes already issued are not undone on a checksum error; `error` tells the system not to release the CPU.
- `start` while `busy` is ignored.
- `reset` in any state:
  - returns to IDLE immediately;
  - clears all outputs;
  - aborts the frame with no further writes.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `error`=0.
- `busy` is high from the cycle after `start` until the cycle DONE or ERROR is entered.
- `wr_en` (registered, so `wr_addr`/`wr_data` are stable when it is sampled):
  - goes high for exactly one cycle, the cycle after the 4th byte of a word is accepted;
  - `wr_addr` and `wr_data` are valid in that same cycle;
  - `wr_addr`/`wr_data` hold their last values when `wr_en` is low.
- CHKLEN adds one cycle between LEN_LO acceptance and DATA readiness. A `byte_valid` in that cycle is not accepted; the source must be paced by at least one idle cycle after LEN_LO. The UART receiver guarantees this.
- `done`/`error` are set the cycle after CHK is accepted, or the cycle after CHKLEN on overflow. They remain set until the next `start` or `reset`.
- Back-to-back `byte_valid` is supported in DATA: the fastest sustained rate is 1 word per 4 cycles.

## Test plan
- Two-word load:
  - Stimulus: `start`; bytes 00 02 07 E0 00 00 44 00 00 00 A1.
  - Response: writes (1, 0x07E00000) then (2, 0x44000000); `done`=1, `error`=0, `busy`=0.
- Zero length:
  - Stimulus: `start`; bytes 00 00 00.
  - Response: no `wr_en`; `done`=1.
- Bad checksum:
  - Stimulus: same as the two-word load but CHK=A0.
  - Response: both writes occur; `error`=1, `done`=0.
- Overflow:
  - Stimulus: `start`; bytes 02 00 (N=512, BASE_ADDR=1).
  - Response: ERROR after CHKLEN; no `wr_en`; any following bytes are ignored.
- Reset mid-load:
  - Stimulus: assert `reset` after the 2nd data byte of word 0.
  - Response: all outputs 0, no write. A subsequent full two-word frame loads correctly from address 1.
- Start while busy:
  - Stimulus: pulse `start` during DATA.
  - Response: ignored; the frame completes normally with `done`=1. Bytes sent while IDLE produce no writes.
